// File: rtl/freq_meas_ctrl.sv
// Gate-window frequency counter controller: count edges, latch, start BCD conversion, publish.
// Optional macro FMC_OVF_SAT_EN saturates the count at 9999 and reports oOverflow.
module freq_meas_ctrl #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CONV_TMO    = 64
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iEdge,
  input  logic             iConvDone,
  output logic             oGate,
  output logic [CNT_W-1:0] oCount,
  output logic             oConvStart,
  output logic             oValid,
  output logic             oOverflow,
  output logic             oErr,
  output logic [2:0]       oState
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] GATE    = 3'd2;
  localparam logic [2:0] LATCH   = 3'd3;
  localparam logic [2:0] CONVERT = 3'd4;

  localparam int unsigned TMO_W = $clog2(CONV_TMO + 1);
  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CONV_TMO - 1);

  logic [2:0]       state;
  logic [2:0]       stateNext;
  logic [31:0]      gateTmr;
  logic [CNT_W-1:0] edgeCnt;
  logic [CNT_W-1:0] cntNext;
  logic             ovfSeen;
  logic             ovfNext;
  logic [TMO_W-1:0] tmoCnt;
  logic             gateLast;
  logic             convTmo;

  assign gateLast = (gateTmr == GATE_LAST);
  assign convTmo  = (tmoCnt == TMO_LAST);
  assign oState   = state;

  // Converter handshake: oConvStart is a one-cycle request issued in LATCH with oCount
  // already stable; iConvDone is a one-cycle acknowledge honoured only in CONVERT.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iEn) stateNext = CLEAR;
      CLEAR:   stateNext = GATE;
      GATE:    if (gateLast) stateNext = LATCH;
      LATCH:   stateNext = CONVERT;
      CONVERT: if (iConvDone || convTmo) stateNext = iEn ? CLEAR : IDLE;
      default: stateNext = IDLE;
    endcase
  end

`ifdef FMC_OVF_SAT_EN
  localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(9999);

  always_comb begin
    cntNext = edgeCnt;
    ovfNext = ovfSeen;
    if (iEdge) begin
      if (edgeCnt == SAT_MAX) ovfNext = 1'b1;
      else                    cntNext = edgeCnt + CNT_W'(1);
    end
  end
`else
  // Wrapping counter; ovfSeen is never set so oOverflow stays 0.
  always_comb begin
    cntNext = iEdge ? edgeCnt + CNT_W'(1) : edgeCnt;
    ovfNext = ovfSeen;
  end
`endif

  // The last gate cycle's edge is folded in via cntNext so oCount is valid during LATCH.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= IDLE;
      gateTmr    <= '0;
      edgeCnt    <= '0;
      ovfSeen    <= 1'b0;
      tmoCnt     <= '0;
      oCount     <= '0;
      oGate      <= 1'b0;
      oConvStart <= 1'b0;
      oValid     <= 1'b0;
      oOverflow  <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      state      <= stateNext;
      oGate      <= (stateNext == GATE);
      oConvStart <= (stateNext == LATCH);
      oValid     <= (state == CONVERT) && iConvDone;
      case (state)
        CLEAR: begin
          edgeCnt <= '0;
          ovfSeen <= 1'b0;
          gateTmr <= '0;
        end
        GATE: begin
          edgeCnt <= cntNext;
          ovfSeen <= ovfNext;
          gateTmr <= gateTmr + 32'd1;
          if (gateLast) begin
            oCount    <= cntNext;
            oOverflow <= ovfNext;
          end
        end
        LATCH: tmoCnt <= '0;
        CONVERT: begin
          tmoCnt <= tmoCnt + TMO_W'(1);
          if (convTmo && !iConvDone) oErr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: a short-gate instance for cycle-level checks and a 12000-cycle
// gate instance for the display-range case; expectations come from edge patterns the bench draws.
module tb_freq_meas_ctrl;

  localparam int G   = 10;
  localparam int GB  = 12000;
  localparam int TMO = 64;
  localparam int CW  = 16;
  localparam int PAT_N = G + TMO + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, edge_a, done_a;
  logic gate_a, conv_start_a, valid_a, ovf_a, err_a;
  logic [CW-1:0] count_a;
  logic [2:0] state_a;
  logic en_b, edge_b, done_b;
  logic gate_b, conv_start_b, valid_b, ovf_b, err_b;
  logic [CW-1:0] count_b;
  logic [2:0] state_b;

  freq_meas_ctrl #(.GATE_CYCLES(G), .CNT_W(CW), .CONV_TMO(TMO)) dut_a (
    .iClk(clk), .iRst(rst_n), .iEn(en_a), .iEdge(edge_a), .iConvDone(done_a),
    .oGate(gate_a), .oCount(count_a), .oConvStart(conv_start_a), .oValid(valid_a),
    .oOverflow(ovf_a), .oErr(err_a), .oState(state_a)
  );

  freq_meas_ctrl #(.GATE_CYCLES(GB), .CNT_W(CW), .CONV_TMO(TMO)) dut_b (
    .iClk(clk), .iRst(rst_n), .iEn(en_b), .iEdge(edge_b), .iConvDone(done_b),
    .oGate(gate_b), .oCount(count_b), .oConvStart(conv_start_b), .oValid(valid_b),
    .oOverflow(ovf_b), .oErr(err_b), .oState(state_b)
  );

  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] prev_cnt;
  logic prev_ovf;
  logic exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for one measurement: the count is the number of edge pulses the bench drove
  // in gate cycles 1..G (cycle 0 is CLEAR), saturated or wrapped according to the build.
  function automatic logic [CW-1:0] model_count(input int n);
`ifdef FMC_OVF_SAT_EN
    return (n > 9999) ? CW'(9999) : CW'(n);
`else
    return CW'(n);
`endif
  endfunction

  function automatic logic model_ovf(input int n);
`ifdef FMC_OVF_SAT_EN
    return n > 9999;
`else
    return (n < 0);
`endif
  endfunction

  // Entered in the CLEAR cycle; leaves in the cycle after conversion ends.
  // mode: 0 edges on even cycles, 1 edges at CLEAR/first/last/LATCH, 2 random, 3 all high.
  // done_dly < 0 means the converter never answers.
  task automatic meas(input int mode, input int done_dly, input bit drop_en);
    bit pat[PAT_N];
    int n;
    int last_c;
    logic exp_ovf;
    logic [CW-1:0] got;
    n = 0;
    for (int i = 0; i < PAT_N; i++) begin
      case (mode)
        0: pat[i] = (i % 2 == 0);
        1: pat[i] = (i == 0) || (i == 1) || (i == G) || (i == G + 1);
        2: pat[i] = 1'($urandom_range(0, 1));
        default: pat[i] = 1'b1;
      endcase
      if (i >= 1 && i <= G && pat[i]) n++;
    end
    exp_q.push_back(model_count(n));
    exp_ovf = model_ovf(n);
    last_c = (done_dly < 0) ? G + 1 + TMO : G + 2 + done_dly;
    for (int c = 0; c <= last_c; c++) begin
      if (c == G + 1) begin
        got = exp_q.pop_front();
        prev_cnt = got;
        prev_ovf = exp_ovf;
      end
      check("gate", 32'(gate_a), 32'(c >= 1 && c <= G));
      check("conv_start", 32'(conv_start_a), 32'(c == G + 1));
      if (c >= 1) check("valid_early", 32'(valid_a), 32'd0);
      check("count", 32'(count_a), 32'(prev_cnt));
      check("overflow", 32'(ovf_a), 32'(prev_ovf));
      check("err", 32'(err_a), 32'(exp_err));
      edge_a = pat[c];
      if (mode == 2 && c <= G + 1) done_a = ($urandom_range(0, 3) == 0);
      else done_a = (c == last_c) && (done_dly >= 0);
      if (drop_en && c == G / 2) en_a = 1'b0;
      step();
    end
    edge_a = 1'b0;
    done_a = 1'b0;
    if (done_dly < 0) exp_err = 1'b1;
    check("valid_exit", 32'(valid_a), 32'(done_dly >= 0));
    check("err_exit", 32'(err_a), 32'(exp_err));
    check("gate_exit", 32'(gate_a), 32'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    en_a = 0; edge_a = 0; done_a = 0;
    en_b = 0; edge_b = 0; done_b = 0;
    prev_cnt = '0;
    prev_ovf = 1'b0;
    exp_err = 1'b0;
    repeat (2) step();
    check("rst_gate", 32'(gate_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_start", 32'(conv_start_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_count_b", 32'(count_b), 32'd0);
    rst_n = 1'b1;

    // Idle with stray edges and conversion pulses: nothing moves.
    for (int i = 0; i < 6; i++) begin
      edge_a = 1'($urandom_range(0, 1));
      done_a = 1'($urandom_range(0, 1));
      step();
      check("idle_gate", 32'(gate_a), 32'd0);
      check("idle_valid", 32'(valid_a), 32'd0);
      check("idle_count", 32'(count_a), 32'd0);
    end
    edge_a = 0;
    done_a = 0;

    // Long gate with the edge input held high: exceeds the 4-digit range.
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    edge_b = 1'b1;
    k = 0;
    while (k <= GB + 50 && conv_start_b !== 1'b1) begin
      step();
      k++;
    end
    check("b_latch_cycle", 32'(k), 32'(GB + 1));
    check("b_count", 32'(count_b), 32'(model_count(GB)));
    check("b_overflow", 32'(ovf_b), 32'(model_ovf(GB)));
    edge_b = 1'b0;
    step();
    done_b = 1'b1;
    step();
    done_b = 1'b0;
    check("b_valid", 32'(valid_b), 32'd1);
    check("b_err", 32'(err_b), 32'd0);

    // Back-to-back measurements on the short-gate instance.
    en_a = 1'b1;
    step();
    meas(0, 3, 1'b0);
    meas(1, 0, 1'b0);
    for (int r = 0; r < 6; r++) meas(2, int'($urandom_range(0, 20)), 1'b0);
    meas(3, 5, 1'b0);
    meas(2, -1, 1'b0);

    // Now in CLEAR after the timeout; reset part-way through the gate.
    edge_a = 1'b1;
    repeat (5) step();
    check("pre_rst_gate", 32'(gate_a), 32'd1);
    edge_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gate", 32'(gate_a), 32'd0);
    check("mid_rst_count", 32'(count_a), 32'd0);
    check("mid_rst_start", 32'(conv_start_a), 32'd0);
    check("mid_rst_valid", 32'(valid_a), 32'd0);
    check("mid_rst_ovf", 32'(ovf_a), 32'd0);
    check("mid_rst_err", 32'(err_a), 32'd0);
    prev_cnt = '0;
    prev_ovf = 1'b0;
    exp_err = 1'b0;
    #2 rst_n = 1'b1;
    step();
    meas(2, int'($urandom_range(0, 10)), 1'b1);

    // Enable dropped mid-gate: cycle completed, now idle until re-enabled.
    for (int i = 0; i < 12; i++) begin
      edge_a = 1'($urandom_range(0, 1));
      done_a = 1'($urandom_range(0, 1));
      step();
      check("stop_gate", 32'(gate_a), 32'd0);
      check("stop_valid", 32'(valid_a), 32'd0);
      check("stop_count", 32'(count_a), 32'(prev_cnt));
    end
    edge_a = 0;
    done_a = 0;
    en_a = 1'b1;
    step();
    meas(0, 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
